// File: rtl/hazard_pkg.sv
// Shared types and field helpers for the pipeline hazard controller.
package hazard_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        MUL_BUSY = 2'd2,
        MUL_LAST = 2'd3
    } hz_state_e;

    // Response selected for the current cycle, in priority-resolved form
    typedef enum logic [2:0] {
        RESP_DEFAULT  = 3'd0,
        RESP_RESET    = 3'd1,
        RESP_HALTED   = 3'd2,
        RESP_BRANCH   = 3'd3,
        RESP_HOLD     = 3'd4,
        RESP_LOAD     = 3'd5,
        RESP_HALT_DET = 3'd6
    } hz_resp_e;

    typedef struct packed {
        logic pc_enable;
        logic if_id_enable;
        logic id_ex_enable;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEFAULT = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam hz_ctrl_t CTRL_HALTED  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam hz_ctrl_t CTRL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam hz_ctrl_t CTRL_HOLD    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_LOAD    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    localparam logic [3:0] DEF_LOAD_OP = 4'h8;
    localparam logic [3:0] DEF_MUL_OP  = 4'h3;
    localparam logic [3:0] DEF_HALT_OP = 4'hF;

    // Field LSB positions; layout from MSB down is opcode, rd, rs, rt
    function automatic int opc_lsb(input int instr_w, input int opc_w);
        return instr_w - opc_w;
    endfunction

    function automatic int rd_lsb(input int instr_w, input int opc_w, input int reg_w);
        return instr_w - opc_w - reg_w;
    endfunction

    function automatic int rs_lsb(input int instr_w, input int opc_w, input int reg_w);
        return instr_w - opc_w - 2 * reg_w;
    endfunction

    function automatic int rt_lsb(input int instr_w, input int opc_w, input int reg_w);
        return instr_w - opc_w - 3 * reg_w;
    endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Compares the EX destination register against the ID register fields.
module hazard_reg_match
    import hazard_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter bit CHECK_RT = 1'b0,
    parameter bit R0_ZERO  = 1'b1
) (
    input  logic [REG_W-1:0] dst_rd,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             match
);

    // A hardwired-zero r0 can never carry a real dependency
    always_comb begin
        match = 1'b0;
        if ((dst_rd == id_rd) || (dst_rd == id_rs) || (CHECK_RT && (dst_rd == id_rt)))
            match = 1'b1;
        if (R0_ZERO && (dst_rd == '0))
            match = 1'b0;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multiply hold, branch flush,
// sticky halt and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no sequence in progress; detect events by priority
// LD_WAIT  | remaining cycles of a multi-cycle load-use stall
// MUL_BUSY | multiply still occupying EX, front end and ID/EX frozen
// MUL_LAST | final multiply cycle, pipeline advances, no re-detect of it
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int               INSTR_W    = 16,
    parameter int               OPC_W      = 4,
    parameter int               REG_W      = 4,
    parameter logic [OPC_W-1:0] LOAD_OP    = OPC_W'(DEF_LOAD_OP),
    parameter logic [OPC_W-1:0] MUL_OP     = OPC_W'(DEF_MUL_OP),
    parameter logic [OPC_W-1:0] HALT_OP    = OPC_W'(DEF_HALT_OP),
    parameter int               LOAD_STALL = 1,
    parameter int               MUL_CYCLES = 4,
    parameter bit               CHECK_RT   = 1'b0,
    parameter bit               R0_ZERO    = 1'b1,
    parameter int               CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction_ID,
    input  logic [INSTR_W-1:0] instruction_EX,
    input  logic               ex_valid,
    input  logic               branch_taken,
    output logic               pc_enable,
    output logic               if_id_enable,
    output logic               id_ex_enable,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               halt,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int OPC_LSB  = opc_lsb(INSTR_W, OPC_W);
    localparam int RD_LSB   = rd_lsb(INSTR_W, OPC_W, REG_W);
    localparam int RS_LSB   = rs_lsb(INSTR_W, OPC_W, REG_W);
    localparam int RT_LSB   = rt_lsb(INSTR_W, OPC_W, REG_W);
    localparam int WAIT_MAX = (LOAD_STALL > MUL_CYCLES) ? LOAD_STALL : MUL_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    logic [OPC_W-1:0]  id_opc;
    logic [OPC_W-1:0]  ex_opc;
    logic [REG_W-1:0]  id_rd;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  ex_rd;
    logic              rd_match;
    logic              ld_hit;
    logic              mul_hit;
    logic              halt_hit;
    logic              unused_instr_bits;

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              halt_q;
    logic [CNT_W-1:0]  stall_q;
    hz_resp_e          resp;
    hz_ctrl_t          ctrl;

    assign id_opc = instruction_ID[OPC_LSB +: OPC_W];
    assign id_rd  = instruction_ID[RD_LSB +: REG_W];
    assign id_rs  = instruction_ID[RS_LSB +: REG_W];
    assign id_rt  = instruction_ID[RT_LSB +: REG_W];
    assign ex_opc = instruction_EX[OPC_LSB +: OPC_W];
    assign ex_rd  = instruction_EX[RD_LSB +: REG_W];

    // EX source fields and any padding below rt play no part in hazards
    assign unused_instr_bits = ^{instruction_ID, instruction_EX};

    hazard_reg_match #(
        .REG_W    (REG_W),
        .CHECK_RT (CHECK_RT),
        .R0_ZERO  (R0_ZERO)
    ) u_reg_match (
        .dst_rd (ex_rd),
        .id_rd  (id_rd),
        .id_rs  (id_rs),
        .id_rt  (id_rt),
        .match  (rd_match)
    );

    // A halt in ID never triggers a load-use stall; single-cycle multiply needs no hold
    assign halt_hit = (id_opc == HALT_OP);
    assign ld_hit   = ex_valid && (ex_opc == LOAD_OP) && rd_match && !halt_hit;
    assign mul_hit  = ex_valid && (ex_opc == MUL_OP) && (MUL_CYCLES > 1);

    // Priority resolution of the response for this cycle
    always_comb begin
        resp = RESP_DEFAULT;
        if (rst) begin
            resp = RESP_RESET;
        end else if (halt_q) begin
            resp = RESP_HALTED;
        end else begin
            case (state_q)
                MUL_BUSY: resp = RESP_HOLD;
                LD_WAIT:  resp = branch_taken ? RESP_BRANCH : RESP_LOAD;
                default: begin
                    if (branch_taken)
                        resp = RESP_BRANCH;
                    else if (mul_hit && (state_q != MUL_LAST))
                        resp = RESP_HOLD;
                    else if (ld_hit)
                        resp = RESP_LOAD;
                    else if (halt_hit)
                        resp = RESP_HALT_DET;
                end
            endcase
        end
    end

    // Next-state and wait-counter load; wait counter exits at zero
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE, MUL_LAST: begin
                state_d = IDLE;
                if (resp == RESP_HOLD) begin
                    if (MUL_CYCLES > 2) begin
                        state_d = MUL_BUSY;
                        wait_d  = WAIT_W'(MUL_CYCLES - 3);
                    end else begin
                        state_d = MUL_LAST;
                    end
                end else if ((resp == RESP_LOAD) && (LOAD_STALL > 1)) begin
                    state_d = LD_WAIT;
                    wait_d  = WAIT_W'(LOAD_STALL - 2);
                end
            end
            LD_WAIT: begin
                if ((resp == RESP_BRANCH) || (wait_q == '0))
                    state_d = IDLE;
                else
                    wait_d = wait_q - WAIT_W'(1);
            end
            MUL_BUSY: begin
                if (wait_q == '0)
                    state_d = MUL_LAST;
                else
                    wait_d = wait_q - WAIT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State, wait counter and sticky halt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            halt_q  <= halt_q || (resp == RESP_HALT_DET);
        end
    end

    // Control outputs from the resolved response
    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (resp)
            RESP_RESET:    ctrl = CTRL_RESET;
            RESP_HALTED:   ctrl = CTRL_HALTED;
            RESP_BRANCH:   ctrl = CTRL_BRANCH;
            RESP_HOLD:     ctrl = CTRL_HOLD;
            RESP_LOAD:     ctrl = CTRL_LOAD;
            RESP_HALT_DET: ctrl = CTRL_LOAD;
            default:       ctrl = CTRL_DEFAULT;
        endcase
    end

    // Stall cycles stop counting once halted; count saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (!ctrl.pc_enable && !halt_q && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign pc_enable    = ctrl.pc_enable;
    assign if_id_enable = ctrl.if_id_enable;
    assign id_ex_enable = ctrl.id_ex_enable;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign halt         = halt_q && !rst;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven with identical stimulus.
// A: defaults (LOAD_STALL=1, MUL_CYCLES=4, CHECK_RT=0, CNT_W=16)
// B: LOAD_STALL=3, MUL_CYCLES=2, CHECK_RT=1, CNT_W=4
module tb_hazard_ctrl;

    localparam int CW_A = 16;
    localparam int CW_B = 4;

    // {pc_enable, if_id_enable, id_ex_enable, if_id_flush, id_ex_flush, halt}
    localparam logic [5:0] O_RST  = 6'b000110;
    localparam logic [5:0] O_DEF  = 6'b111000;
    localparam logic [5:0] O_LDU  = 6'b001010;
    localparam logic [5:0] O_HOLD = 6'b000000;
    localparam logic [5:0] O_BR   = 6'b111110;
    localparam logic [5:0] O_HLT  = 6'b001111;

    typedef struct {
        int ls;
        int mc;
        bit crt;
        bit r0;
        int cw;
    } cfg_t;

    // Model state: remaining stall/hold cycles rather than an FSM
    typedef struct {
        int ld_left;
        int mul_left;
        bit mul_last;
        bit halted;
        int cnt;
    } mst_t;

    typedef struct {
        logic [15:0] ex;
        logic        v;
        logic [15:0] id;
        logic        br;
        logic [5:0]  la;
        logic [5:0]  lb;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [15:0]     instr_id = '0;
    logic [15:0]     instr_ex = '0;
    logic            ex_valid = 1'b0;
    logic            branch_taken = 1'b0;

    logic            pc_a, ifid_a, idex_a, iff_a, idf_a, halt_a;
    logic [CW_A-1:0] cnt_a;
    logic            pc_b, ifid_b, idex_b, iff_b, idf_b, halt_b;
    logic [CW_B-1:0] cnt_b;
    logic [5:0]      got_a, got_b, exp_a, exp_b;

    cfg_t cfg_a = '{ls: 1, mc: 4, crt: 1'b0, r0: 1'b1, cw: CW_A};
    cfg_t cfg_b = '{ls: 3, mc: 2, crt: 1'b1, r0: 1'b1, cw: CW_B};
    mst_t st_a, st_b, nx_a, nx_b;
    int   checks = 0;
    int   fails  = 0;

    assign got_a = {pc_a, ifid_a, idex_a, iff_a, idf_a, halt_a};
    assign got_b = {pc_b, ifid_b, idex_b, iff_b, idf_b, halt_b};

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .instruction_ID(instr_id), .instruction_EX(instr_ex),
        .ex_valid(ex_valid), .branch_taken(branch_taken),
        .pc_enable(pc_a), .if_id_enable(ifid_a), .id_ex_enable(idex_a),
        .if_id_flush(iff_a), .id_ex_flush(idf_a), .halt(halt_a), .stall_cycles(cnt_a)
    );

    hazard_ctrl #(.LOAD_STALL(3), .MUL_CYCLES(2), .CHECK_RT(1'b1), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .instruction_ID(instr_id), .instruction_EX(instr_ex),
        .ex_valid(ex_valid), .branch_taken(branch_taken),
        .pc_enable(pc_b), .if_id_enable(ifid_b), .id_ex_enable(idex_b),
        .if_id_flush(iff_b), .id_ex_flush(idf_b), .halt(halt_b), .stall_cycles(cnt_b)
    );

    function automatic void model(input cfg_t c, input mst_t s, output logic [5:0] o, output mst_t n);
        int ex_opc, ex_rd, id_opc, id_rd, id_rs, id_rt;
        bit dep, ld, mul;
        ex_opc = int'(instr_ex[15:12]);
        ex_rd  = int'(instr_ex[11:8]);
        id_opc = int'(instr_id[15:12]);
        id_rd  = int'(instr_id[11:8]);
        id_rs  = int'(instr_id[7:4]);
        id_rt  = int'(instr_id[3:0]);
        dep = (ex_rd == id_rd) || (ex_rd == id_rs) || (c.crt && (ex_rd == id_rt));
        ld  = ex_valid && (ex_opc == 8) && dep && !(c.r0 && ex_rd == 0) && (id_opc != 15);
        mul = ex_valid && (ex_opc == 3) && (c.mc > 1);
        n = s;
        n.mul_last = 1'b0;
        if (rst) begin
            o = O_RST;
            n = '{ld_left: 0, mul_left: 0, mul_last: 1'b0, halted: 1'b0, cnt: 0};
            return;
        end
        if (s.halted) begin
            o = O_HLT;
        end else if (s.mul_left > 0) begin
            o = O_HOLD;
            n.mul_left = s.mul_left - 1;
            n.mul_last = (n.mul_left == 0);
        end else if (s.ld_left > 0) begin
            if (branch_taken) begin
                o = O_BR;
                n.ld_left = 0;
            end else begin
                o = O_LDU;
                n.ld_left = s.ld_left - 1;
            end
        end else if (branch_taken) begin
            o = O_BR;
        end else if (mul && !s.mul_last) begin
            o = O_HOLD;
            n.mul_left = c.mc - 2;
            n.mul_last = (n.mul_left == 0);
        end else if (ld) begin
            o = O_LDU;
            n.ld_left = c.ls - 1;
        end else if (id_opc == 15) begin
            o = O_LDU;
            n.halted = 1'b1;
        end else begin
            o = O_DEF;
        end
        if (!o[5] && !s.halted && (s.cnt < (1 << c.cw) - 1))
            n.cnt = s.cnt + 1;
    endfunction

    task automatic drive(input logic r, input logic [15:0] id, input logic [15:0] ex,
                         input logic v, input logic br);
        rst = r;
        instr_id = id;
        instr_ex = ex;
        ex_valid = v;
        branch_taken = br;
    endtask

    task automatic settle();
        #1;
        model(cfg_a, st_a, exp_a, nx_a);
        model(cfg_b, st_b, exp_b, nx_b);
    endtask

    task automatic advance();
        assert (rst || !branch_taken || (st_a.mul_left == 0 && st_b.mul_left == 0))
            else $error("branch_taken driven while a multiply holds EX");
        @(posedge clk);
        st_a = nx_a;
        st_b = nx_b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        settle();
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h0310, 16'h8120, 1'b1, 1'b1);
        settle();
        checks++; if (got_a !== O_RST) begin fails++; $display("FAIL reset_hold A got=%b exp=%b", got_a, O_RST); end
        checks++; if (got_b !== O_RST) begin fails++; $display("FAIL reset_hold B got=%b exp=%b", got_b, O_RST); end
        advance();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        settle();
        checks++; if (got_a !== O_DEF) begin fails++; $display("FAIL reset_idle A got=%b exp=%b", got_a, O_DEF); end
        checks++; if (got_b !== O_DEF) begin fails++; $display("FAIL reset_idle B got=%b exp=%b", got_b, O_DEF); end
        checks++; if (cnt_a !== '0) begin fails++; $display("FAIL reset_cnt A got=%0d exp=0", cnt_a); end
        checks++; if (cnt_b !== '0) begin fails++; $display("FAIL reset_cnt B got=%0d exp=0", cnt_b); end
        advance();
    endtask

    task automatic test_load_use();
        step_t s [2];
        s = '{'{16'h8120, 1'b1, 16'h0310, 1'b0, O_LDU, O_LDU},
              '{16'h0000, 1'b0, 16'h0310, 1'b0, O_DEF, O_LDU}};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, s[i].id, s[i].ex, s[i].v, s[i].br);
            settle();
            checks++; if (got_a !== s[i].la) begin fails++; $display("FAIL load_use[%0d] A got=%b exp=%b", i, got_a, s[i].la); end
            checks++; if (got_b !== s[i].lb) begin fails++; $display("FAIL load_use[%0d] B got=%b exp=%b", i, got_b, s[i].lb); end
            checks++; if (got_a !== exp_a) begin fails++; $display("FAIL load_use_model[%0d] A got=%b exp=%b", i, got_a, exp_a); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL load_use_model[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            advance();
        end
        checks++; if (cnt_a !== 16'd1) begin fails++; $display("FAIL load_use_cnt A got=%0d exp=1", cnt_a); end
    endtask

    task automatic test_ld_stall3();
        step_t s [4];
        step_t t [3];
        s = '{'{16'h8120, 1'b1, 16'h0310, 1'b0, O_LDU, O_LDU},
              '{16'h0000, 1'b0, 16'h0310, 1'b0, O_DEF, O_LDU},
              '{16'h0000, 1'b0, 16'h0310, 1'b0, O_DEF, O_LDU},
              '{16'h0000, 1'b0, 16'h0310, 1'b0, O_DEF, O_DEF}};
        t = '{'{16'h8120, 1'b1, 16'h0310, 1'b0, O_LDU, O_LDU},
              '{16'h0000, 1'b0, 16'h0310, 1'b1, O_BR,  O_BR},
              '{16'h0000, 1'b0, 16'h0310, 1'b0, O_DEF, O_DEF}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, s[i].id, s[i].ex, s[i].v, s[i].br);
            settle();
            checks++; if (got_a !== s[i].la) begin fails++; $display("FAIL ld_stall3[%0d] A got=%b exp=%b", i, got_a, s[i].la); end
            checks++; if (got_b !== s[i].lb) begin fails++; $display("FAIL ld_stall3[%0d] B got=%b exp=%b", i, got_b, s[i].lb); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL ld_stall3_model[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            advance();
        end
        checks++; if (cnt_b !== 4'd3) begin fails++; $display("FAIL ld_stall3_cnt B got=%0d exp=3", cnt_b); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, t[i].id, t[i].ex, t[i].v, t[i].br);
            settle();
            checks++; if (got_a !== t[i].la) begin fails++; $display("FAIL ld_abort[%0d] A got=%b exp=%b", i, got_a, t[i].la); end
            checks++; if (got_b !== t[i].lb) begin fails++; $display("FAIL ld_abort[%0d] B got=%b exp=%b", i, got_b, t[i].lb); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL ld_abort_model[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            advance();
        end
        checks++; if (cnt_b !== 4'd1) begin fails++; $display("FAIL ld_abort_cnt B got=%0d exp=1", cnt_b); end
    endtask

    task automatic test_r0_check_rt();
        step_t s [2];
        s = '{'{16'h8020, 1'b1, 16'h0100, 1'b0, O_DEF, O_DEF},
              '{16'h8520, 1'b1, 16'h0015, 1'b0, O_DEF, O_LDU}};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, s[i].id, s[i].ex, s[i].v, s[i].br);
            settle();
            checks++; if (got_a !== s[i].la) begin fails++; $display("FAIL r0_rt[%0d] A got=%b exp=%b", i, got_a, s[i].la); end
            checks++; if (got_b !== s[i].lb) begin fails++; $display("FAIL r0_rt[%0d] B got=%b exp=%b", i, got_b, s[i].lb); end
            checks++; if (got_a !== exp_a) begin fails++; $display("FAIL r0_rt_model[%0d] A got=%b exp=%b", i, got_a, exp_a); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL r0_rt_model[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            advance();
        end
    endtask

    task automatic test_multiply();
        step_t s [5];
        s = '{'{16'h3123, 1'b1, 16'h0456, 1'b0, O_HOLD, O_HOLD},
              '{16'h3123, 1'b1, 16'h0456, 1'b0, O_HOLD, O_DEF},
              '{16'h3123, 1'b1, 16'h0456, 1'b0, O_HOLD, O_HOLD},
              '{16'h3123, 1'b1, 16'h0456, 1'b0, O_DEF,  O_DEF},
              '{16'h0456, 1'b1, 16'h0000, 1'b0, O_DEF,  O_DEF}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, s[i].id, s[i].ex, s[i].v, s[i].br);
            settle();
            checks++; if (got_a !== s[i].la) begin fails++; $display("FAIL multiply[%0d] A got=%b exp=%b", i, got_a, s[i].la); end
            checks++; if (got_b !== s[i].lb) begin fails++; $display("FAIL multiply[%0d] B got=%b exp=%b", i, got_b, s[i].lb); end
            checks++; if (got_a !== exp_a) begin fails++; $display("FAIL multiply_model[%0d] A got=%b exp=%b", i, got_a, exp_a); end
            advance();
        end
        checks++; if (cnt_a !== 16'd3) begin fails++; $display("FAIL multiply_cnt A got=%0d exp=3", cnt_a); end
    endtask

    task automatic test_halt();
        step_t s [4];
        s = '{'{16'h8120, 1'b1, 16'hF120, 1'b0, O_LDU, O_LDU},
              '{16'h0000, 1'b0, 16'h0310, 1'b1, O_HLT, O_HLT},
              '{16'h8120, 1'b1, 16'h0310, 1'b0, O_HLT, O_HLT},
              '{16'h3123, 1'b1, 16'h0000, 1'b0, O_HLT, O_HLT}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, s[i].id, s[i].ex, s[i].v, s[i].br);
            settle();
            checks++; if (got_a !== s[i].la) begin fails++; $display("FAIL halt[%0d] A got=%b exp=%b", i, got_a, s[i].la); end
            checks++; if (got_b !== s[i].lb) begin fails++; $display("FAIL halt[%0d] B got=%b exp=%b", i, got_b, s[i].lb); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL halt_model[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            advance();
        end
        checks++; if (cnt_a !== 16'd1) begin fails++; $display("FAIL halt_cnt A got=%0d exp=1", cnt_a); end
        checks++; if (cnt_b !== 4'd1) begin fails++; $display("FAIL halt_cnt B got=%0d exp=1", cnt_b); end
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        settle();
        checks++; if (got_a !== O_RST) begin fails++; $display("FAIL halt_rst A got=%b exp=%b", got_a, O_RST); end
        advance();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        settle();
        checks++; if (got_a !== O_DEF) begin fails++; $display("FAIL halt_clear A got=%b exp=%b", got_a, O_DEF); end
        checks++; if (cnt_a !== '0) begin fails++; $display("FAIL halt_clear_cnt A got=%0d exp=0", cnt_a); end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 16'h0310, 16'h8120, 1'b1, 1'b0);
            settle();
            checks++; if (got_a !== exp_a) begin fails++; $display("FAIL saturate[%0d] A got=%b exp=%b", i, got_a, exp_a); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL saturate[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            advance();
        end
        checks++; if (cnt_a !== 16'd20) begin fails++; $display("FAIL saturate_cnt A got=%0d exp=20", cnt_a); end
        checks++; if (cnt_b !== 4'd15) begin fails++; $display("FAIL saturate_cnt B got=%0d exp=15", cnt_b); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(1'b0, 16'h0310, 16'h8120, 1'b1, 1'b0);
        settle();
        advance();
        drive(1'b1, 16'h0310, 16'h8120, 1'b1, 1'b0);
        settle();
        checks++; if (got_b !== O_RST) begin fails++; $display("FAIL rst_mid B got=%b exp=%b", got_b, O_RST); end
        advance();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        settle();
        checks++; if (got_b !== O_DEF) begin fails++; $display("FAIL rst_mid_idle B got=%b exp=%b", got_b, O_DEF); end
        checks++; if (cnt_b !== '0) begin fails++; $display("FAIL rst_mid_cnt B got=%0d exp=0", cnt_b); end
        advance();
    endtask

    function automatic logic [15:0] rand_instr(input bit allow_halt);
        logic [3:0] opc;
        int r;
        r = $urandom_range(0, 9);
        if (r <= 2)               opc = 4'h8;
        else if (r <= 4)          opc = 4'h3;
        else if (r == 5 && allow_halt) opc = 4'hF;
        else                      opc = 4'($urandom_range(0, 2));
        return {opc, 2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
                2'b00, 2'($urandom_range(0, 3))};
    endfunction

    task automatic test_random();
        int halt_run = 0;
        logic r, br;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 49) == 0) || (halt_run >= 4);
            br = ($urandom_range(0, 9) == 0) && (st_a.mul_left == 0) && (st_b.mul_left == 0);
            drive(r, rand_instr($urandom_range(0, 7) == 0), rand_instr(1'b0),
                  $urandom_range(0, 4) != 0, br);
            settle();
            checks++; if (got_a !== exp_a) begin fails++; $display("FAIL random[%0d] A got=%b exp=%b", i, got_a, exp_a); end
            checks++; if (got_b !== exp_b) begin fails++; $display("FAIL random[%0d] B got=%b exp=%b", i, got_b, exp_b); end
            checks++; if (cnt_a !== CW_A'(st_a.cnt)) begin fails++; $display("FAIL random_cnt[%0d] A got=%0d exp=%0d", i, cnt_a, st_a.cnt); end
            checks++; if (cnt_b !== CW_B'(st_b.cnt)) begin fails++; $display("FAIL random_cnt[%0d] B got=%0d exp=%0d", i, cnt_b, st_b.cnt); end
            advance();
            halt_run = (st_a.halted || st_b.halted) ? halt_run + 1 : 0;
        end
    endtask

    initial begin
        st_a = '{ld_left: 0, mul_left: 0, mul_last: 1'b0, halted: 1'b0, cnt: 0};
        st_b = st_a;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_ld_stall3();
        test_r0_check_rt();
        test_multiply();
        test_halt();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
